// File: rtl/cache_pkg.sv
// Shared types and constants for the cache read/write data paths.
package cache_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BEATS  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Expand a 4-bit byte enable into a 32-bit lane mask.
    function automatic logic [WORD_W-1:0] bval_mask(input logic [3:0] bval);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{bval[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/read_data_if.sv
// Request/response bundle between the cache controller, data array, memory and read_data.
interface read_data_if
    import cache_pkg::*;
#(
    parameter int unsigned CACHE_STR_WIDTH = 64,
    parameter int unsigned OFFSET_WIDTH    = 3
) ();

    logic                       hit_req;
    logic                       fill_req;
    logic [CACHE_STR_WIDTH-1:0] cache_data;
    logic [OFFSET_WIDTH-1:0]    offset;
    logic [3:0]                 sys_bval;
    logic [WORD_W-1:0]          mem_rdata;
    logic                       mem_rvalid;
    logic [WORD_W-1:0]          sys_rdata;
    logic                       sys_ack;
    logic [CACHE_STR_WIDTH-1:0] fill_data;
    logic                       fill_we;
    logic                       busy;

    modport master (
        output hit_req, fill_req, cache_data, offset, sys_bval, mem_rdata, mem_rvalid,
        input  sys_rdata, sys_ack, fill_data, fill_we, busy
    );

    modport slave (
        input  hit_req, fill_req, cache_data, offset, sys_bval, mem_rdata, mem_rvalid,
        output sys_rdata, sys_ack, fill_data, fill_we, busy
    );

endinterface

// File: rtl/rdata_mask.sv
// Selects one 32-bit word out of a line and zeroes the disabled byte lanes.
module rdata_mask
    import cache_pkg::*;
#(
    parameter int unsigned CACHE_STR_WIDTH = 64,
    parameter int unsigned IDX_W           = 1
) (
    input  logic [CACHE_STR_WIDTH-1:0] line,
    input  logic [IDX_W-1:0]           word_idx,
    input  logic [3:0]                 bval,
    output logic [WORD_W-1:0]          word
);

    localparam int unsigned N_WORDS = CACHE_STR_WIDTH / WORD_W;

    logic [WORD_W-1:0] sel;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < N_WORDS; i++) begin
            if (word_idx == IDX_W'(i)) begin
                sel = line[i*WORD_W +: WORD_W];
            end
        end
        word = sel & bval_mask(bval);
    end

endmodule

// File: rtl/read_data.sv
// Cache read-return path: serves hits from the array, assembles misses from memory
// beats with early critical-word forwarding, and hands the full line to the array.
module read_data
    import cache_pkg::*;
#(
    parameter int unsigned CACHE_STR_WIDTH = 64,
    parameter int unsigned OFFSET_WIDTH    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    read_data_if.slave  bus
);

    localparam int unsigned LINE_BEATS = CACHE_STR_WIDTH / WORD_W;
    localparam int unsigned IDX_W      = $clog2(LINE_BEATS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_BEATS - 1);

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]           word_idx_q, word_idx_d;
    logic [3:0]                 bval_q, bval_d;
    logic [CACHE_STR_WIDTH-1:0] line_buf_q, line_buf_d;
    logic [WORD_W-1:0]          sys_rdata_q, sys_rdata_d;
    logic                       sys_ack_q, sys_ack_d;
    logic [CACHE_STR_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                       fill_we_q, fill_we_d;

    logic [CACHE_STR_WIDTH-1:0] mask_line;
    logic [IDX_W-1:0]           mask_idx;
    logic [3:0]                 mask_bval;
    logic [WORD_W-1:0]          mask_word;
    logic                       last_beat;

    assign last_beat = (beat_cnt_q == LAST_BEAT);

    // One masker serves both paths: during a fill the beat is replicated across the
    // line so the latched word index always lands on the incoming beat.
    rdata_mask #(
        .CACHE_STR_WIDTH (CACHE_STR_WIDTH),
        .IDX_W           (IDX_W)
    ) u_rdata_mask (
        .line     (mask_line),
        .word_idx (mask_idx),
        .bval     (mask_bval),
        .word     (mask_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!bus.hit_req && bus.fill_req) state_d = FILL;
            FILL: if (bus.mem_rvalid && last_beat)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        word_idx_d  = word_idx_q;
        bval_d      = bval_q;
        line_buf_d  = line_buf_q;
        sys_rdata_d = sys_rdata_q;
        sys_ack_d   = 1'b0;
        fill_data_d = fill_data_q;
        fill_we_d   = 1'b0;
        mask_line   = bus.cache_data;
        mask_idx    = bus.offset[OFFSET_WIDTH-1 -: IDX_W];
        mask_bval   = bus.sys_bval;

        case (state_q)
            IDLE: begin
                if (bus.hit_req) begin
                    sys_ack_d   = 1'b1;
                    sys_rdata_d = mask_word;
                end else if (bus.fill_req) begin
                    word_idx_d = bus.offset[OFFSET_WIDTH-1 -: IDX_W];
                    bval_d     = bus.sys_bval;
                    beat_cnt_d = '0;
                end
            end
            FILL: begin
                mask_line = {LINE_BEATS{bus.mem_rdata}};
                mask_idx  = word_idx_q;
                mask_bval = bval_q;
                if (bus.mem_rvalid) begin
                    for (int unsigned i = 0; i < LINE_BEATS; i++) begin
                        if (beat_cnt_q == IDX_W'(i)) begin
                            line_buf_d[i*WORD_W +: WORD_W] = bus.mem_rdata;
                        end
                    end
                    if (beat_cnt_q == word_idx_q) begin
                        sys_ack_d   = 1'b1;
                        sys_rdata_d = mask_word;
                    end
                    if (last_beat) begin
                        fill_we_d   = 1'b1;
                        fill_data_d = line_buf_d;
                        beat_cnt_d  = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            word_idx_q  <= '0;
            bval_q      <= '0;
            line_buf_q  <= '0;
            sys_rdata_q <= '0;
            sys_ack_q   <= 1'b0;
            fill_data_q <= '0;
            fill_we_q   <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            word_idx_q  <= word_idx_d;
            bval_q      <= bval_d;
            line_buf_q  <= line_buf_d;
            sys_rdata_q <= sys_rdata_d;
            sys_ack_q   <= sys_ack_d;
            fill_data_q <= fill_data_d;
            fill_we_q   <= fill_we_d;
        end
    end

    assign bus.sys_rdata = sys_rdata_q;
    assign bus.sys_ack   = sys_ack_q;
    assign bus.fill_data = fill_data_q;
    assign bus.fill_we   = fill_we_q;
    assign bus.busy      = (state_q == FILL);

    a_no_dual_req: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(state_q == IDLE && bus.hit_req && bus.fill_req)
    );

endmodule

// File: tb/tb_read_data.sv
// Self-checking bench for read_data: hit vector table, directed fill corners, random traffic.
module tb_read_data;
    import cache_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    read_data_if #(.CACHE_STR_WIDTH(64), .OFFSET_WIDTH(3)) bus ();

    read_data #(.CACHE_STR_WIDTH(64), .OFFSET_WIDTH(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] line;
        logic [2:0]  off;
        logic [3:0]  bval;
        logic [31:0] exp;
    } hit_vec_t;

    hit_vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: pick word offset[2] of the line, clear disabled bytes.
    function automatic logic [31:0] ref_word(input logic [63:0] line, input logic [2:0] off,
                                             input logic [3:0] bval);
        logic [63:0] sh;
        logic [31:0] w;
        sh = line >> (off[2] ? 32 : 0);
        w  = sh[31:0];
        for (int b = 0; b < 4; b++) if (!bval[b]) w[b*8 +: 8] = 8'h00;
        return w;
    endfunction

    task automatic do_hit(input logic [63:0] line, input logic [2:0] off,
                          input logic [3:0] bval, input logic [31:0] exp, input string tag);
        bus.hit_req    = 1'b1;
        bus.cache_data = line;
        bus.offset     = off;
        bus.sys_bval   = bval;
        tick();
        bus.hit_req = 1'b0;
        chk({tag, "_ack"},   64'(bus.sys_ack), 64'd1);
        chk({tag, "_rdata"}, 64'(bus.sys_rdata), 64'(exp));
        chk({tag, "_busy"},  64'(bus.busy), 64'd0);
        chk({tag, "_we"},    64'(bus.fill_we), 64'd0);
    endtask

    task automatic do_fill(input logic [2:0] off, input logic [3:0] bval,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input int g0, input int g1, input bit hit_in_gap, input string tag);
        logic [31:0] beats[2];
        int          gaps[2];
        int          req;
        logic [31:0] exp;
        beats[0] = b0; beats[1] = b1;
        gaps[0]  = g0; gaps[1]  = g1;
        req      = off[2] ? 1 : 0;
        exp      = ref_word({b1, b0}, off, bval);

        bus.fill_req = 1'b1;
        bus.offset   = off;
        bus.sys_bval = bval;
        tick();
        bus.fill_req = 1'b0;
        chk({tag, "_start_busy"}, 64'(bus.busy), 64'd1);
        chk({tag, "_start_ack"},  64'(bus.sys_ack), 64'd0);

        for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < gaps[b]; g++) begin
                bus.mem_rvalid = 1'b0;
                bus.offset     = 3'($urandom);
                bus.sys_bval   = 4'($urandom);
                if (hit_in_gap) begin
                    bus.hit_req    = 1'b1;
                    bus.cache_data = {$urandom, $urandom};
                end
                tick();
                bus.hit_req = 1'b0;
                chk({tag, "_gap_ack"},  64'(bus.sys_ack), 64'd0);
                chk({tag, "_gap_busy"}, 64'(bus.busy), 64'd1);
                chk({tag, "_gap_we"},   64'(bus.fill_we), 64'd0);
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = beats[b];
            tick();
            bus.mem_rvalid = 1'b0;
            chk({tag, "_beat_ack"}, 64'(bus.sys_ack), 64'(b == req));
            if (b == req) chk({tag, "_fwd_rdata"}, 64'(bus.sys_rdata), 64'(exp));
            chk({tag, "_beat_we"},   64'(bus.fill_we), 64'(b == 1));
            chk({tag, "_beat_busy"}, 64'(bus.busy), 64'(b != 1));
        end
        chk({tag, "_fill_data"}, bus.fill_data, {b1, b0});
        chk({tag, "_rdata_hold"}, 64'(bus.sys_rdata), 64'(exp));
    endtask

    initial begin
        bus.hit_req    = 1'b0;
        bus.fill_req   = 1'b0;
        bus.cache_data = '0;
        bus.offset     = '0;
        bus.sys_bval   = '0;
        bus.mem_rdata  = '0;
        bus.mem_rvalid = 1'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack",   64'(bus.sys_ack), 64'd0);
        chk("rst_busy",  64'(bus.busy), 64'd0);
        chk("rst_we",    64'(bus.fill_we), 64'd0);
        chk("rst_rdata", 64'(bus.sys_rdata), 64'd0);
        chk("rst_fdata", bus.fill_data, 64'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Hit vector table
        vecs[0] = '{64'hDEADBEEF_01234567, 3'b100, 4'b1111, 32'hDEADBEEF};
        vecs[1] = '{64'hDEADBEEF_01234567, 3'b000, 4'b0101, 32'h00230067};
        vecs[2] = '{64'hDEADBEEF_01234567, 3'b111, 4'b1010, 32'hDE00BE00};
        vecs[3] = '{64'hDEADBEEF_01234567, 3'b011, 4'b0000, 32'h00000000};
        vecs[4] = '{64'hDEADBEEF_01234567, 3'b001, 4'b1000, 32'h01000000};
        vecs[5] = '{64'h11223344_55667788, 3'b110, 4'b0011, 32'h00003344};
        for (int i = 0; i < 6; i++) begin
            do_hit(vecs[i].line, vecs[i].off, vecs[i].bval, vecs[i].exp, $sformatf("hitvec%0d", i));
        end
        tick();
        chk("ack_pulse", 64'(bus.sys_ack), 64'd0);
        chk("rdata_hold_idle", 64'(bus.sys_rdata), 64'h00003344);

        // Fill, word 0, back-to-back beats; then word 1 with gaps and a hit in the gap
        do_fill(3'b000, 4'b1111, 32'hAAAA0000, 32'hBBBB1111, 0, 0, 1'b0, "fill_w0");
        tick();
        chk("we_pulse", 64'(bus.fill_we), 64'd0);
        do_fill(3'b100, 4'b1111, 32'hAAAA0000, 32'hBBBB1111, 0, 3, 1'b1, "fill_w1_gap");

        // Reset mid-fill
        bus.fill_req = 1'b1; bus.offset = 3'b100; bus.sys_bval = 4'b1111;
        tick();
        bus.fill_req = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(bus.busy), 64'd0);
        chk("mid_rst_rdata", 64'(bus.sys_rdata), 64'd0);
        chk("mid_rst_fdata", bus.fill_data, 64'd0);
        chk("mid_rst_ack",   64'(bus.sys_ack), 64'd0);
        chk("mid_rst_we",    64'(bus.fill_we), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("stray_ack",  64'(bus.sys_ack), 64'd0);
        chk("stray_we",   64'(bus.fill_we), 64'd0);
        chk("stray_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("stray_ack2", 64'(bus.sys_ack), 64'd0);
        chk("stray_we2",  64'(bus.fill_we), 64'd0);

        // Back-to-back: new fill accepted in the fill_we cycle
        do_fill(3'b000, 4'b0110, 32'h01020304, 32'h05060708, 0, 0, 1'b0, "b2b_a");
        bus.fill_req = 1'b1; bus.offset = 3'b100; bus.sys_bval = 4'b1001;
        tick();
        bus.fill_req = 1'b0;
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        chk("b2b_we",   64'(bus.fill_we), 64'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h99887766;
        tick();
        chk("b2b_beat0_ack", 64'(bus.sys_ack), 64'd0);
        bus.mem_rdata = 32'h55443322;
        tick();
        bus.mem_rvalid = 1'b0;
        chk("b2b_beat1_ack",   64'(bus.sys_ack), 64'd1);
        chk("b2b_beat1_we",    64'(bus.fill_we), 64'd1);
        chk("b2b_beat1_rdata", 64'(bus.sys_rdata), 64'h55000022);
        chk("b2b_fdata",       bus.fill_data, 64'h55443322_99887766);

        // Random traffic against the reference
        for (int n = 0; n < 40; n++) begin
            logic [63:0] line;
            logic [2:0]  off;
            logic [3:0]  bv;
            line = {$urandom, $urandom};
            off  = 3'($urandom);
            bv   = 4'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                do_hit(line, off, bv, ref_word(line, off, bv), $sformatf("rhit%0d", n));
            end else begin
                do_fill(off, bv, line[31:0], line[63:32], int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rfill%0d", n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
